// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder/decoder pair: FSM states,
// byte geometry and the byte-select helper.
package rle_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    // Byte offsets within a {symbol, count} pair
    localparam logic SYM_OFF = 1'b0;
    localparam logic CNT_OFF = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_EXPAND,
        S_WR,
        S_FLUSH,
        S_DONE
    } state_t;

    function automatic logic [BYTE_W-1:0] word_byte(
        input logic [BYTE_W*WORD_BYTES-1:0] w,
        input logic [1:0]                   idx
    );
        return w[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/rld_if.sv
// Word-only DPSRAM port A as seen by the run-length decoder.
interface rld_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_we,
        output port_A_data_in,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_we,
        input  port_A_data_in,
        output port_A_data_out
    );
endinterface

// File: rtl/rld_pack.sv
// Output word packer: collects expanded bytes little-endian into one word.
// data is the buffer with the incoming byte merged, so a full or flushed word
// can be captured on the same edge that delivers its last byte.
module rld_pack
    import rle_pkg::*;
(
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [BYTE_W-1:0]            byte_in,
    input  logic [1:0]                   byte_idx,
    output logic [BYTE_W*WORD_BYTES-1:0] data,
    output logic                         full
);
    logic [BYTE_W*WORD_BYTES-1:0] buffer;

    always_comb begin
        data = buffer;
        if (wr_en) data[byte_idx*BYTE_W +: BYTE_W] = byte_in;
    end

    assign full = wr_en && (byte_idx == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)    buffer <= '0;
        else if (clear) buffer <= '0;
        else if (wr_en) buffer <= data;
    end
endmodule

// File: rtl/rld.sv
// Run-length decoder: reads {symbol, count} pairs from DPSRAM, expands them
// and writes packed output words back, reporting the expanded byte count.
module rld
    import rle_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] out_addr,
    output logic [31:0] out_size,
    output logic        done,
    rld_if.master       mem
);
    state_t            state, state_n, pend, pend_n, nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_n, wr_addr, wr_addr_n, addr_n;
    logic [30:0]       pairs, pairs_n;
    logic [31:0]       in_word, in_word_n, size_n, wdata_n;
    logic [7:0]        run, run_n, sym, cnt;
    logic              sel, sel_n, done_n, we_n, emit, pack_clear, last;
    logic [31:0]       pack_data;
    logic              pack_full;
    logic              unused_addr_bits;

    assign mem.port_A_clk   = clk;
    assign unused_addr_bits = ^{rle_addr, out_addr};

    assign sym  = word_byte(in_word, {sel, SYM_OFF});
    assign cnt  = word_byte(in_word, {sel, CNT_OFF});
    assign last = (cnt == 8'd0) || (run == cnt - 8'd1);

    rld_pack u_pack (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (pack_clear),
        .wr_en    (emit),
        .byte_in  (sym),
        .byte_idx (out_size[1:0]),
        .data     (pack_data),
        .full     (pack_full)
    );

    always_comb begin
        state_n    = state;
        pend_n     = pend;
        nxt        = S_EXPAND;
        rd_addr_n  = rd_addr;
        wr_addr_n  = wr_addr;
        pairs_n    = pairs;
        in_word_n  = in_word;
        sel_n      = sel;
        run_n      = run;
        size_n     = out_size;
        done_n     = done;
        we_n       = 1'b0;
        addr_n     = mem.port_A_addr;
        wdata_n    = mem.port_A_data_in;
        emit       = 1'b0;
        pack_clear = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (state == S_DONE) done_n = 1'b1;
                if (start) begin
                    done_n     = 1'b0;
                    size_n     = '0;
                    pack_clear = 1'b1;
                    in_word_n  = '0;
                    sel_n      = 1'b0;
                    run_n      = '0;
                    pairs_n    = rle_size[31:1];
                    rd_addr_n  = {rle_addr[ADDR_W-1:2], 2'b00};
                    wr_addr_n  = {out_addr[ADDR_W-1:2], 2'b00};
                    state_n    = (rle_size < 32'd2) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ:  state_n = S_RD_WAIT;
            S_RD_WAIT: begin
                in_word_n = mem.port_A_data_out;
                state_n   = S_EXPAND;
            end
            S_EXPAND: begin
                if (cnt != 8'd0) begin
                    emit   = 1'b1;
                    size_n = out_size + 32'd1;
                    run_n  = run + 8'd1;
                end
                if (last) begin
                    run_n   = '0;
                    sel_n   = ~sel;
                    pairs_n = pairs - 31'd1;
                    if (pairs == 31'd1) nxt = S_FLUSH;
                    else if (sel)       nxt = S_RD_REQ;
                end
                // A full word detours through WR and then resumes the pending step
                if (pack_full) begin
                    pack_clear = 1'b1;
                    pend_n     = nxt;
                    state_n    = S_WR;
                end else begin
                    state_n = nxt;
                end
            end
            S_WR:    state_n = pend;
            S_FLUSH: begin
                pack_clear = 1'b1;
                state_n    = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        // Port outputs are registered, so they are loaded on entry to the access cycle
        if (state_n == S_RD_REQ) begin
            addr_n    = rd_addr_n;
            rd_addr_n = rd_addr_n + ADDR_W'(4);
        end
        if (state_n == S_WR || (state_n == S_FLUSH && state != S_FLUSH && size_n[1:0] != 2'd0)) begin
            we_n      = 1'b1;
            addr_n    = wr_addr;
            wdata_n   = pack_data;
            wr_addr_n = wr_addr + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state              <= S_IDLE;
            pend               <= S_IDLE;
            rd_addr            <= '0;
            wr_addr            <= '0;
            pairs              <= '0;
            in_word            <= '0;
            sel                <= 1'b0;
            run                <= '0;
            out_size           <= '0;
            done               <= 1'b0;
            mem.port_A_we      <= 1'b0;
            mem.port_A_addr    <= '0;
            mem.port_A_data_in <= '0;
        end else begin
            state              <= state_n;
            pend               <= pend_n;
            rd_addr            <= rd_addr_n;
            wr_addr            <= wr_addr_n;
            pairs              <= pairs_n;
            in_word            <= in_word_n;
            sel                <= sel_n;
            run                <= run_n;
            out_size           <= size_n;
            done               <= done_n;
            mem.port_A_we      <= we_n;
            mem.port_A_addr    <= addr_n;
            mem.port_A_data_in <= wdata_n;
        end
    end
endmodule

// File: tb/tb_rld.sv
// Directed bench for rld: table of small streams plus hand sequences for
// timing, long runs, asynchronous reset and a 39-byte round-trip frame.
module tb_rld;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rle_addr = '0, rle_size = '0, out_addr = '0;
    logic [31:0] out_size;
    logic        done;

    rld_if #(.ADDR_W(16)) mif ();

    rld #(.ADDR_W(16)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .start    (start),
        .rle_addr (rle_addr),
        .rle_size (rle_size),
        .out_addr (out_addr),
        .out_size (out_size),
        .done     (done),
        .mem      (mif.master)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] IN_W  = 10'h100;
    localparam logic [9:0] OUT_W = 10'h200;

    // Memory model: registered read, write when we; bench preloads via ld_*
    logic [31:0] mem [0:1023];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (mif.port_A_we) begin
            mem[mif.port_A_addr[11:2]] <= mif.port_A_data_in;
            wr_count <= wr_count + 1;
        end
        mif.port_A_data_out <= mem[mif.port_A_addr[11:2]];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic mem_put(input logic [9:0] idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_out(input int n);
        for (int i = 0; i < n; i++) mem_put(OUT_W + 10'(i), 32'hDEAD_BEEF);
    endtask

    task automatic start_job(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] oa);
        @(negedge clk);
        rle_addr = ra; rle_size = rs; out_addr = oa; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [31:0] w0, w1, size, exp_size;
        int          nwr;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t vecs [4];
    int   base, bad, found;
    logic [31:0] w;

    initial begin
        vecs[0] = '{32'h0142_0341, 32'h0244_0243, 32'd8, 32'd8, 2, 32'h4241_4141, 32'h4444_4343};
        vecs[1] = '{32'h0000_055A, 32'h0000_0000, 32'd2, 32'd5, 2, 32'h5A5A_5A5A, 32'h0000_005A};
        vecs[2] = '{32'h0222_0011, 32'h0000_0000, 32'd4, 32'd2, 1, 32'h0000_2222, 32'hDEAD_BEEF};
        vecs[3] = '{32'h00AB_0133, 32'h0000_0000, 32'd3, 32'd1, 1, 32'h0000_0033, 32'hDEAD_BEEF};

        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_size", out_size, 32'd0);
        check("rst_we", 32'(mif.port_A_we), 32'd0);
        check("rst_addr", 32'(mif.port_A_addr), 32'd0);
        check("rst_data_in", mif.port_A_data_in, 32'd0);
        check("port_clk_low", 32'(mif.port_A_clk), 32'd0);
        nreset = 1'b1;

        // Low address bits and bits above ADDR_W must be ignored
        for (int v = 0; v < 4; v++) begin
            mem_put(IN_W, vecs[v].w0);
            mem_put(IN_W + 10'd1, vecs[v].w1);
            clear_out(2);
            base = wr_count;
            start_job(32'h0001_0400 | 32'(v), vecs[v].size, 32'h0002_0800 | 32'(3 - v));
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_out_size", v), out_size, vecs[v].exp_size);
            check($sformatf("v%0d_writes", v), 32'(wr_count - base), 32'(vecs[v].nwr));
            check($sformatf("v%0d_word0", v), mem[OUT_W], vecs[v].e0);
            check($sformatf("v%0d_word1", v), mem[OUT_W + 10'd1], vecs[v].e1);
        end

        // rle_size = 0: done drops at the accepting edge and rises one edge later
        base = wr_count;
        @(negedge clk);
        rle_size = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("sz0_done_edge1", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("sz0_done_edge2", 32'(done), 32'd1);
        check("sz0_out_size", out_size, 32'd0);
        check("sz0_writes", 32'(wr_count - base), 32'd0);

        // Longest single run
        mem_put(IN_W, 32'h0000_FFFF);
        clear_out(65);
        base = wr_count;
        start_job(32'h400, 32'd2, 32'h800);
        wait_done("run255");
        check("run255_out_size", out_size, 32'd255);
        check("run255_writes", 32'(wr_count - base), 32'd64);
        bad = 0;
        for (int i = 0; i < 63; i++) if (mem[OUT_W + 10'(i)] !== 32'hFFFF_FFFF) bad++;
        check("run255_full_words_bad", 32'(bad), 32'd0);
        check("run255_last_word", mem[OUT_W + 10'd63], 32'h00FF_FFFF);
        check("run255_beyond", mem[OUT_W + 10'd64], 32'hDEAD_BEEF);

        // Asynchronous reset while done is high
        @(negedge clk); #2;
        nreset = 1'b0;
        #1;
        check("arst_done", 32'(done), 32'd0);
        check("arst_out_size", out_size, 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        // Asynchronous reset during an output write cycle
        mem_put(IN_W, 32'h0000_C85A);
        start_job(32'h400, 32'd2, 32'h800);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (mif.port_A_we) found = 1;
        end
        check("midjob_we_seen", 32'(found), 32'd1);
        #1;
        nreset = 1'b0;
        #1;
        check("midjob_rst_we", 32'(mif.port_A_we), 32'd0);
        check("midjob_rst_done", 32'(done), 32'd0);
        check("midjob_rst_addr", 32'(mif.port_A_addr), 32'd0);
        check("midjob_rst_out_size", out_size, 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        // 39 distinct bytes compress to 39 pairs of count 1 (rle_size 78)
        for (int j = 0; j < 20; j++) begin
            w = {8'h01, 8'h30 + 8'(2 * j + 1), 8'h01, 8'h30 + 8'(2 * j)};
            mem_put(IN_W + 10'(j), w);
        end
        clear_out(11);
        base = wr_count;
        start_job(32'h400, 32'd78, 32'h800);
        wait_done("frame39");
        check("frame39_out_size", out_size, 32'd39);
        check("frame39_writes", 32'(wr_count - base), 32'd10);
        bad = 0;
        for (int m = 0; m < 10; m++) begin
            for (int b = 0; b < 4; b++) begin
                w[8*b +: 8] = (4 * m + b < 39) ? 8'h30 + 8'(4 * m + b) : 8'h00;
            end
            if (mem[OUT_W + 10'(m)] !== w) begin
                bad++;
                $display("FAIL frame39_word%0d: got 0x%08h expected 0x%08h", m, mem[OUT_W + 10'(m)], w);
            end
        end
        check("frame39_words_bad", 32'(bad), 32'd0);
        check("frame39_beyond", mem[OUT_W + 10'd10], 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rld.md
# rld

Run-length decoder that sits directly downstream of `rle` in the compression datapath. After `start`, it reads a compressed stream of {symbol, count} byte pairs from the shared DPSRAM through port A. It expands each pair into `count` copies of `symbol`, writes the expanded bytes back to DPSRAM as packed words at `out_addr`, and reports the expanded length. It uses the same word-only DPSRAM port and the same start/done protocol as `rle`, so the same bench memory model can drive it for round-trip checks.

## Interface
- `ADDR_W`, default 16: width of `port_A_addr`.
- `clk` in 1: system clock.
- `nreset` in 1: reset; one clock, asynchronous assert, active-low.
- `start` in 1: begin decoding; sampled only in IDLE.
- `rle_addr` in 32: byte address of the compressed stream; bits [1:0] are ignored.
- `rle_size` in 32: compressed length in bytes.
- `out_addr` in 32: byte address for the expanded output; bits [1:0] are ignored.
- `out_size` out 32: expanded length in bytes; valid while `done`=1.
- `done` out 1: job complete; held high until the next accepted `start`.
- `port_A_clk` out 1: equal to `clk`.
- `port_A_addr` out ADDR_W: word-aligned byte address.
- `port_A_we` out 1: 1 = write, 0 = read.
- `port_A_data_in` out 32: write data to memory.
- `port_A_data_out` in 32: read data from memory; registered by the memory on the `port_A_clk` edge.

## Operation
- Byte packing is little-endian: byte i of a word occupies bits [8i+7:8i]. A pair is byte 2k = symbol, byte 2k+1 = count, so a word holds 2 pairs and no pair straddles two words.
- FSM states:
  - IDLE: `start`=1 latches all inputs and clears `out_size`, `done` and both buffers.
    - If `rle_size` < 2, go to DONE.
    - Otherwise go to RD_REQ.
  - RD_REQ: drive `port_A_addr` = next input word, `we`=0; go to RD_WAIT.
  - RD_WAIT: the memory updates `port_A_data_out` at this cycle's opening edge. Latch it into the input word register at the closing edge; go to EXPAND.
  - EXPAND: one output byte per cycle.
    - Append `symbol` to the output word buffer at byte index `out_size`[1:0].
    - Increment `out_size` and the run counter.
    - When the buffer fills (4th byte), go to WR.
    - At end of run, advance to the next pair.
      - If no complete pairs remain in `rle_size`, go to FLUSH.
      - Else if the word is exhausted, go to RD_REQ.
    - A pair with count 0 is consumed in one cycle with no output.
  - WR: drive `port_A_addr` = next output word, `port_A_data_in` = buffer, `we`=1 for exactly one cycle. Clear the buffer, then resume EXPAND, or RD_REQ/FLUSH per the pending condition.
  - FLUSH: if the buffer holds 1–3 bytes, write it once with the unused upper bytes zero. Go to DONE.
  - DONE: `done`=1. `start`=1 returns to the IDLE acceptance path in the same cycle.
- An odd `rle_size` drops the final unpaired byte without writing anything for it.
- `start` outside IDLE/DONE is ignored.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.
- Reads never go beyond `floor(rle_size/4)` words (+1 if a partial pair word exists).

## Timing
- Reset values:
  - `done`=0, `out_size`=0, `port_A_we`=0, `port_A_addr`=0, `port_A_data_in`=0.
  - FSM in IDLE.
- Asynchronous `nreset` mid-job aborts immediately, with `we` low from the reset edge on. A partial output word is lost.
- Outputs are registered. `port_A_we` is high only in the WR or FLUSH write cycle.
- Per input word: 2 read cycles. Per output byte: 1 cycle. Per written word: 1 cycle. Each zero-count pair costs 1 cycle.
- From `start` with `rle_size`<2, `done` rises 2 edges later.

## Structure
- Shared package `rle_pkg`:
  - FSM state enum.
  - `BYTE_W`=8.
  - `WORD_BYTES`=4.
  - Pair byte offsets.
  - This package is shared with `rle`.
- One sub-module is natural: `rld_pack`, the output word packer. It takes byte-in plus byte index and provides full/flush data.

## Test plan
- Stream words {0x0142_0341, 0x0244_0243}, `rle_size`=8 -> `out_size`=8, word0=0x4241_4141, word1=0x4444_4343, exactly 2 writes.
- Single pair (0x5A, 5) -> `out_size`=5, words 0x5A5A5A5A and 0x0000005A.
- Pairs (0x11, 0), (0x22, 2), `rle_size`=4 -> `out_size`=2, one write 0x0000_2222.
- `rle_size`=0, then `rle_size`=3 (pair (0x33, 1) plus a stray byte) -> first job: `done` in 2 edges, `out_size`=0, no writes. Second job: `out_size`=1.
- Pair (0xFF, 255) -> `out_size`=255, 63 words 0xFFFFFFFF, last word 0x00FFFFFF.
- Pull `nreset` low mid-EXPAND -> `done`/`we` low immediately. A re-run of the 39-byte frame compressed by `rle` (`rle_size` 78) restores the original 39 bytes.
